ram_readback_checker: RTL and testbench
=======================================

RAM_READBACK_CHECKER -- requirements
Module: ram_readback_checker

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 1, clock cycles from address presented to RAM q valid (legal 1..3).
REQ-002 SHALL have parameter PATTERN_OFFSET, default 8'd0, expected data = addr + PATTERN_OFFSET mod 256.
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port wren  input  1  RAM write enable from test generator; 1 = write cycle, 0 = read cycle.
REQ-006 SHALL have port addr  input  8  RAM address driven by generator.
REQ-007 SHALL have port data  input  8  RAM write data driven by generator.
REQ-008 SHALL have port q  input  8  RAM read data, valid RD_LATENCY cycles after addr.
REQ-009 SHALL have port err_cnt  output  16  mismatches in current/last read sweep.
REQ-010 SHALL have port pass  output  1  last completed sweep had zero mismatches and at least one checked location.
REQ-011 SHALL have port sweep_done  output  1  one-cycle pulse at sweep completion.
REQ-012 SHALL have port first_err_addr  output  8  address of first mismatch in sweep.
REQ-013 SHALL have port first_err_data  output  8  q value of first mismatch in sweep.

Function
REQ-014 SHALL implement FSM states IDLE, WRITE, READ, REPORT.
REQ-015 IDLE->WRITE when wren=1; WRITE->READ on first cycle with wren=0; READ->REPORT when delayed address equals 8'd255; REPORT->IDLE unconditionally after one cycle.
REQ-016 In READ, wren=1 SHALL abort the sweep: go to WRITE, no sweep_done, pass unchanged.
REQ-017 SHALL keep a 256-bit written map; set bit addr on every cycle with wren=1; clear all bits on IDLE->WRITE.
REQ-018 Written data equal to addr + PATTERN_OFFSET SHALL be the only legal pattern; no shadow copy of data stored.
REQ-019 SHALL delay addr and a read-valid flag through an RD_LATENCY-deep pipeline; comparison uses delayed address against q.
REQ-020 A delayed location SHALL be checked only if read-valid and written-map bit set; unwritten locations never count as errors.
REQ-021 Mismatch SHALL increment err_cnt, saturating at 16'hFFFF.
REQ-022 err_cnt SHALL clear on WRITE->READ transition.
REQ-023 In REPORT, pass SHALL load (err_cnt==0 && checked_cnt!=0); sweep_done=1 that cycle only; pass sticky until next REPORT.
REQ-024 Mismatch on the same cycle as READ->REPORT SHALL be counted before pass evaluation.
REQ-025 Address wrap 255->0 in READ before pipeline drains SHALL not start a new sweep until REPORT completes.

Reset
REQ-026 On rst_n=0: state IDLE, pipeline and written map cleared, err_cnt=0, pass=0, sweep_done=0, first_err_addr=0, first_err_data=0.
REQ-027 Reset mid-sweep SHALL discard all progress; no sweep_done emitted.

Configuration
REQ-028 Macro RAM_CHK_FIRST_ERR_EN defined: first_err_addr/first_err_data capture first mismatch per sweep, cleared on WRITE->READ.
REQ-029 Macro undefined: first_err_addr and first_err_data SHALL be constant 0, no capture registers.

Structure
REQ-030 Shared package ram_test_pkg SHALL hold FSM state encoding, ADDR_W=8, DATA_W=8, ERR_CNT_W=16.
REQ-031 Latency pipeline SHALL be sub-module ram_rd_delay_line (addr + valid, depth RD_LATENCY).

Verification
REQ-032 Write addr 1..255 data=addr, read 0..255, RD_LATENCY=1, RAM model correct -> sweep_done pulse once, err_cnt=0, pass=1.
REQ-033 Same, RAM model corrupts addr 8'h40 to 8'hFF -> err_cnt=1, pass=0, first_err_addr=8'h40, first_err_data=8'hFF (macro on), 0/0 (macro off).
REQ-034 RD_LATENCY=2, all 256 locations corrupted -> err_cnt=255 (addr 0 unwritten skipped), pass=0.
REQ-035 wren=1 asserted at read addr 8'h80 -> no sweep_done, pass retains previous value, FSM in WRITE.
REQ-036 rst_n low at read addr 8'h10 then release and full clean sweep -> all outputs 0 after reset, then pass=1 at completion.

Source files
------------

// File: rtl/ram_test_pkg.sv
// Shared types and widths for the RAM readback checker.
package ram_test_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int ERR_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_READ   = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

endpackage

// File: rtl/ram_rd_delay_line.sv
// Aligns the presented read address and its valid flag with RAM q, DEPTH cycles later.
module ram_rd_delay_line
  import ram_test_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              valid_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic              valid_out
);

  logic [ADDR_W-1:0] addr_pipe [DEPTH];
  logic [DEPTH-1:0]  valid_pipe;

  // flush drops reads still in flight so an aborted sweep cannot leak into the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) addr_pipe[i] <= '0;
      valid_pipe <= '0;
    end else begin
      addr_pipe[0]  <= addr_in;
      valid_pipe[0] <= valid_in & ~flush;
      for (int i = 1; i < DEPTH; i++) begin
        addr_pipe[i]  <= addr_pipe[i-1];
        valid_pipe[i] <= valid_pipe[i-1] & ~flush;
      end
    end
  end

  assign addr_out  = addr_pipe[DEPTH-1];
  assign valid_out = valid_pipe[DEPTH-1];

endmodule

// File: rtl/ram_readback_checker.sv
// Checks a RAM write/read sweep against the pattern addr + PATTERN_OFFSET.
// Define RAM_CHK_FIRST_ERR_EN to capture the first mismatching address/data per sweep.
//
// state     | meaning
// ST_IDLE   | waiting for the generator to start writing
// ST_WRITE  | write phase, building the written map
// ST_READ   | read phase, comparing delayed address pattern against q
// ST_REPORT | one cycle: sweep_done pulse, pass updated
module ram_readback_checker
  import ram_test_pkg::*;
#(
  parameter int              RD_LATENCY     = 1,
  parameter logic [DATA_W-1:0] PATTERN_OFFSET = 8'd0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wren,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    data,
  input  logic [DATA_W-1:0]    q,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 pass,
  output logic                 sweep_done,
  output logic [ADDR_W-1:0]    first_err_addr,
  output logic [DATA_W-1:0]    first_err_data
);

  state_t state, state_nxt;

  logic [(1<<ADDR_W)-1:0] written;
  logic [ADDR_W:0]        checked_cnt;
  logic [ADDR_W-1:0]      dly_addr;
  logic                   dly_valid;
  logic [DATA_W-1:0]      expected;
  logic start_write, start_read, rd_valid, flush, check, mismatch;

  // write data is not stored; the pattern itself is the expected value
  logic [DATA_W-1:0] data_unused;
  assign data_unused = data;

  assign start_write = (state == ST_IDLE) && wren;
  assign start_read  = (state == ST_WRITE) && !wren;
  assign rd_valid    = !wren && ((state == ST_WRITE) || (state == ST_READ));
  assign flush       = (state == ST_READ) && wren;
  assign expected    = dly_addr + PATTERN_OFFSET;
  assign check       = (state == ST_READ) && dly_valid && written[dly_addr];
  assign mismatch    = check && (q != expected);
  assign sweep_done  = (state == ST_REPORT);

  ram_rd_delay_line #(.DEPTH(RD_LATENCY)) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .addr_in   (addr),
    .valid_in  (rd_valid),
    .addr_out  (dly_addr),
    .valid_out (dly_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (wren) state_nxt = ST_WRITE;
      ST_WRITE:  if (!wren) state_nxt = ST_READ;
      ST_READ: begin
        if (wren)                                   state_nxt = ST_WRITE;
        else if (dly_valid && (dly_addr == 8'hFF))  state_nxt = ST_REPORT;
      end
      ST_REPORT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written <= '0;
    end else if (start_write) begin
      written       <= '0;
      written[addr] <= 1'b1;
    end else if (wren) begin
      written[addr] <= 1'b1;
    end
  end

  // pass reads err_cnt in REPORT, so a mismatch on the last READ cycle is already included
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt     <= '0;
      checked_cnt <= '0;
      pass        <= 1'b0;
    end else begin
      if (start_read) begin
        err_cnt     <= '0;
        checked_cnt <= '0;
      end else begin
        if (mismatch && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
        if (check && (checked_cnt != '1)) checked_cnt <= checked_cnt + 1'b1;
      end
      if (state == ST_REPORT) pass <= (err_cnt == '0) && (checked_cnt != '0);
    end
  end

`ifdef RAM_CHK_FIRST_ERR_EN
  logic first_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_seen     <= 1'b0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (start_read) begin
      first_seen     <= 1'b0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (mismatch && !first_seen) begin
      first_seen     <= 1'b1;
      first_err_addr <= dly_addr;
      first_err_data <= q;
    end
  end
`else
  assign first_err_addr = '0;
  assign first_err_data = '0;
`endif

endmodule

// File: tb/tb_ram_readback_checker.sv
// Directed bench: latency-1 and latency-2 checkers share one generator, each fed by its own RAM model.
module tb_ram_readback_checker;
  import ram_test_pkg::*;

`ifdef RAM_CHK_FIRST_ERR_EN
  localparam bit FE_ON = 1'b1;
`else
  localparam bit FE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wren = 1'b0;
  logic [7:0]  addr = '0;
  logic [7:0]  data = '0;
  logic [7:0]  q1, q2, q2a;
  logic [15:0] err1, err2;
  logic        pass1, pass2, sd1, sd2;
  logic [7:0]  fea1, fed1, fea2, fed2;

  logic [7:0]  mem [256];
  int          mode = 0;  // 0 clean, 1 corrupt 0x40 -> 0xFF, 2 invert every location
  int          n_cmp = 0;
  int          n_err = 0;
  int          done1 = 0;
  int          done2 = 0;

  always #5 clk = ~clk;

  ram_readback_checker #(.RD_LATENCY(1), .PATTERN_OFFSET(8'd0)) dut1 (
    .clk(clk), .rst_n(rst_n), .wren(wren), .addr(addr), .data(data), .q(q1),
    .err_cnt(err1), .pass(pass1), .sweep_done(sd1),
    .first_err_addr(fea1), .first_err_data(fed1)
  );

  ram_readback_checker #(.RD_LATENCY(2), .PATTERN_OFFSET(8'd0)) dut2 (
    .clk(clk), .rst_n(rst_n), .wren(wren), .addr(addr), .data(data), .q(q2),
    .err_cnt(err2), .pass(pass2), .sweep_done(sd2),
    .first_err_addr(fea2), .first_err_data(fed2)
  );

  function automatic logic [7:0] ram_out(input logic [7:0] a, input logic [7:0] d);
    if (mode == 1 && a == 8'h40) return 8'hFF;
    if (mode == 2)               return ~d;
    return d;
  endfunction

  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

  always @(posedge clk) begin
    if (wren) mem[addr] <= data;
    q1  <= ram_out(addr, mem[addr]);
    q2a <= ram_out(addr, mem[addr]);
    q2  <= q2a;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  task automatic step(input logic w, input logic [7:0] a, input logic [7:0] d);
    wren = w; addr = a; data = d;
    @(negedge clk);
    if (sd1) done1++;
    if (sd2) done2++;
    @(posedge clk); #1;
  endtask

  task automatic write_phase();
    for (int i = 1; i < 256; i++) step(1'b1, 8'(i), 8'(i));
  endtask

  task automatic full_sweep(input int m);
    mode = m; done1 = 0; done2 = 0;
    write_phase();
    for (int i = 0; i < 256; i++) step(1'b0, 8'(i), 8'h00);
    for (int i = 0; i < 6; i++) step(1'b0, 8'hFF, 8'h00);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (err1 !== 16'd0 || err2 !== 16'd0) begin n_err++; $display("FAIL reset_err_cnt: got %0d/%0d want 0", err1, err2); end
    n_cmp++; if (pass1 !== 1'b0 || pass2 !== 1'b0) begin n_err++; $display("FAIL reset_pass: got %b/%b want 0", pass1, pass2); end
    n_cmp++; if (sd1 !== 1'b0 || sd2 !== 1'b0) begin n_err++; $display("FAIL reset_sweep_done: got %b/%b want 0", sd1, sd2); end
    n_cmp++; if (fea1 !== 8'h00 || fed1 !== 8'h00 || fea2 !== 8'h00 || fed2 !== 8'h00) begin n_err++; $display("FAIL reset_first_err: got %h %h %h %h want 0", fea1, fed1, fea2, fed2); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_clean_sweep(input string tag);
    full_sweep(0);
    n_cmp++; if (done1 !== 1 || done2 !== 1) begin n_err++; $display("FAIL %s_done_pulses: got %0d/%0d want 1", tag, done1, done2); end
    n_cmp++; if (err1 !== 16'd0 || err2 !== 16'd0) begin n_err++; $display("FAIL %s_err_cnt: got %0d/%0d want 0", tag, err1, err2); end
    n_cmp++; if (pass1 !== 1'b1 || pass2 !== 1'b1) begin n_err++; $display("FAIL %s_pass: got %b/%b want 1", tag, pass1, pass2); end
    n_cmp++; if (fea1 !== 8'h00 || fed1 !== 8'h00) begin n_err++; $display("FAIL %s_first_err: got %h/%h want 00/00", tag, fea1, fed1); end
  endtask

  task automatic test_single_corrupt();
    logic [7:0] exp_a, exp_d;
    exp_a = FE_ON ? 8'h40 : 8'h00;
    exp_d = FE_ON ? 8'hFF : 8'h00;
    full_sweep(1);
    n_cmp++; if (done1 !== 1 || done2 !== 1) begin n_err++; $display("FAIL single_done_pulses: got %0d/%0d want 1", done1, done2); end
    n_cmp++; if (err1 !== 16'd1) begin n_err++; $display("FAIL single_err_cnt_l1: got %0d want 1", err1); end
    n_cmp++; if (err2 !== 16'd1) begin n_err++; $display("FAIL single_err_cnt_l2: got %0d want 1", err2); end
    n_cmp++; if (pass1 !== 1'b0 || pass2 !== 1'b0) begin n_err++; $display("FAIL single_pass: got %b/%b want 0", pass1, pass2); end
    n_cmp++; if (fea1 !== exp_a || fed1 !== exp_d) begin n_err++; $display("FAIL single_first_err_l1: got %h/%h want %h/%h", fea1, fed1, exp_a, exp_d); end
    n_cmp++; if (fea2 !== exp_a || fed2 !== exp_d) begin n_err++; $display("FAIL single_first_err_l2: got %h/%h want %h/%h", fea2, fed2, exp_a, exp_d); end
  endtask

  task automatic test_all_corrupt();
    logic [7:0] exp_a, exp_d;
    exp_a = FE_ON ? 8'h01 : 8'h00;
    exp_d = FE_ON ? 8'hFE : 8'h00;
    full_sweep(2);
    n_cmp++; if (err2 !== 16'd255) begin n_err++; $display("FAIL all_err_cnt_l2: got %0d want 255", err2); end
    n_cmp++; if (err1 !== 16'd255) begin n_err++; $display("FAIL all_err_cnt_l1: got %0d want 255", err1); end
    n_cmp++; if (pass1 !== 1'b0 || pass2 !== 1'b0) begin n_err++; $display("FAIL all_pass: got %b/%b want 0", pass1, pass2); end
    n_cmp++; if (fea2 !== exp_a || fed2 !== exp_d) begin n_err++; $display("FAIL all_first_err_l2: got %h/%h want %h/%h", fea2, fed2, exp_a, exp_d); end
  endtask

  task automatic test_abort();
    mode = 0; done1 = 0; done2 = 0;
    write_phase();
    for (int i = 0; i < 8'h80; i++) step(1'b0, 8'(i), 8'h00);
    step(1'b1, 8'h80, 8'h80);
    n_cmp++; if (dut1.state !== ST_WRITE || dut2.state !== ST_WRITE) begin n_err++; $display("FAIL abort_state: got %0d/%0d want %0d", dut1.state, dut2.state, ST_WRITE); end
    for (int i = 0; i < 5; i++) step(1'b1, 8'h81 + 8'(i), 8'h81 + 8'(i));
    n_cmp++; if (done1 !== 0 || done2 !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d/%0d want 0", done1, done2); end
    n_cmp++; if (pass1 !== 1'b1 || pass2 !== 1'b1) begin n_err++; $display("FAIL abort_pass_kept: got %b/%b want 1", pass1, pass2); end
    n_cmp++; if (dut1.state !== ST_WRITE) begin n_err++; $display("FAIL abort_state_hold: got %0d want %0d", dut1.state, ST_WRITE); end
  endtask

  task automatic test_reset_mid_sweep();
    mode = 0; done1 = 0; done2 = 0;
    write_phase();
    for (int i = 0; i < 8'h10; i++) step(1'b0, 8'(i), 8'h00);
    wren = 1'b0; addr = 8'h10;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (err1 !== 16'd0 || err2 !== 16'd0) begin n_err++; $display("FAIL midrst_err_cnt: got %0d/%0d want 0", err1, err2); end
    n_cmp++; if (pass1 !== 1'b0 || pass2 !== 1'b0) begin n_err++; $display("FAIL midrst_pass: got %b/%b want 0", pass1, pass2); end
    n_cmp++; if (sd1 !== 1'b0 || sd2 !== 1'b0 || done1 !== 0 || done2 !== 0) begin n_err++; $display("FAIL midrst_done: got %b/%b cnt %0d/%0d want 0", sd1, sd2, done1, done2); end
    n_cmp++; if (fea1 !== 8'h00 || fed1 !== 8'h00 || fea2 !== 8'h00 || fed2 !== 8'h00) begin n_err++; $display("FAIL midrst_first_err: got %h %h %h %h want 0", fea1, fed1, fea2, fed2); end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_clean_sweep("post_reset");
  endtask

  initial begin
    test_reset();
    test_clean_sweep("clean");
    test_single_corrupt();
    test_all_corrupt();
    test_clean_sweep("clean_again");
    test_abort();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
